// File: rtl/sym_arb_pkg.sv
// sym_arb_pkg: shared state encoding, symbol width and result record for sym_arbiter
package sym_arb_pkg;
  localparam int SYM_W = 2;
  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;
  typedef struct packed {
    logic             id;
    logic [SYM_W-1:0] y;
  } res_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick, the requester not served last wins a tie
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);
  assign grant = &req ? ~last : req[1];
endmodule

// File: rtl/sym_arbiter.sv
// sym_arbiter: bursts from two requesters share one Moore detector, flushed per burst
// Optional SYM_ARB_TIMEOUT_EN aborts a burst stalled for TIMEOUT consecutive cycles.
module sym_arbiter
  import sym_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_vld,
  input  logic [SYM_W-1:0] req0_sym,
  input  logic             req0_last,
  output logic             req0_rdy,
  input  logic             req1_vld,
  input  logic [SYM_W-1:0] req1_sym,
  input  logic             req1_last,
  output logic             req1_rdy,
  output logic             det_rst,
  output logic             det_en,
  output logic [SYM_W-1:0] det_a,
  input  logic [SYM_W-1:0] det_y,
  output logic             res_vld,
  output logic             res_id,
  output logic [SYM_W-1:0] res_y,
  output logic             busy
);
  state_t state, state_nx;
  logic grant, last_grant, pick, acc, to, res_v, res_i, g_vld, g_last;
  logic [SYM_W-1:0] g_sym;
  res_t res;
  assign g_vld  = grant ? req1_vld : req0_vld;
  assign g_last = grant ? req1_last : req0_last;
  assign g_sym  = grant ? req1_sym : req0_sym;
  rr_pick2 u_pick (.req({req1_vld, req0_vld}), .last(last_grant), .grant(pick));
  always_comb begin
    state_nx = state;
    acc      = 1'b0;
    det_rst  = 1'b0;
    case (state)
      IDLE:  state_nx = (req0_vld | req1_vld) ? FLUSH : IDLE;
      FLUSH: begin
        det_rst  = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        acc      = g_vld;
        det_rst  = to;
        state_nx = (g_vld && g_last) ? DRAIN : to ? IDLE : RUN;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
`ifdef SYM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign to = state == RUN && !g_vld && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == RUN && !g_vld && !to) ? cnt + 1'b1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign to = 1'b0;
`endif
  // grant is frozen from IDLE until the burst ends; pointer moves only when it ends
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      res_v      <= 1'b0;
      res_i      <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= state == IDLE ? pick : grant;
      last_grant <= (state == DRAIN || to) ? grant : last_grant;
      res_v      <= acc;
      res_i      <= grant;
    end
  assign res.id   = res_v & res_i;
  assign res.y    = res_v ? det_y : '0;
  assign res_vld  = res_v;
  assign res_id   = res.id;
  assign res_y    = res.y;
  assign req0_rdy = acc & ~grant;
  assign req1_rdy = acc & grant;
  assign det_en   = acc;
  assign det_a    = acc ? g_sym : '0;
  assign busy     = state != IDLE;
endmodule

// File: tb/tb_sym_arbiter.sv
// tb_sym_arbiter: randomized bursts against a burst-level scoreboard of expected results
module tb_sym_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic vld[2], lst[2];
  logic [1:0] sym[2];
  logic rdy0, rdy1, det_rst, det_en, res_vld, res_id, busy;
  logic [1:0] det_a, det_y, res_y;
  logic [1:0] det_st = 2'd0;
  int total = 0, bad = 0;
  logic [1:0] bq[2][$];
  int acc_cnt[2], stall_left[2], force_stall[2];
  int order[$], exp_q[$];
  int last_w, cyc = 0, gap_start = 0;
  logic rdy_s[2];
  logic acc_prev, saw_rst, prev_rst, gap_chk;

  always #5 clk = ~clk;

  sym_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(vld[0]), .req0_sym(sym[0]), .req0_last(lst[0]), .req0_rdy(rdy0),
    .req1_vld(vld[1]), .req1_sym(sym[1]), .req1_last(lst[1]), .req1_rdy(rdy1),
    .det_rst(det_rst), .det_en(det_en), .det_a(det_a), .det_y(det_y),
    .res_vld(res_vld), .res_id(res_id), .res_y(res_y), .busy(busy)
  );

  // detector stand-in: running sum of symbols, cleared by det_rst
  assign det_y = det_st;
  always @(posedge clk) det_st <= det_rst ? 2'd0 : det_en ? det_st + det_a : det_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (bq[n].size() == 0 || stall_left[n] > 0) begin
        vld[n] = 1'b0;
        sym[n] = 2'($urandom);
        lst[n] = 1'($urandom);
        if (stall_left[n] > 0) stall_left[n]--;
      end else begin
        vld[n] = 1'b1;
        sym[n] = bq[n][0];
        lst[n] = bq[n].size() == 1;
      end
    end
  endtask

  task automatic monitor();
    logic r[2];
    int own;
    r[0] = rdy0;
    r[1] = rdy1;
    cyc++;
    check("rdy_excl", r[0] & r[1], 0);
    check("det_en", det_en, r[0] | r[1]);
    check("res_lat", res_vld, acc_prev);
    if (res_vld) begin
      if (exp_q.size() == 0) check("res_extra", 1, 0);
      else begin
        int e;
        e = exp_q.pop_front();
        check("res_id", res_id, e / 4);
        check("res_y", res_y, e % 4);
      end
      check("res_y_copy", res_y, det_y);
    end
    if (det_rst) begin
      check("flush_rdy", r[0] | r[1], 0);
      check("flush_width", prev_rst, 0);
      if (gap_chk) begin
        check("idle_gap", cyc - gap_start, 3);
        gap_chk = 1'b0;
      end
      saw_rst = 1'b1;
    end
    for (int n = 0; n < 2; n++)
      if (r[n]) begin
        own = order.size() ? order[0] : 2;
        check("owner", n, own);
        check("rdy_vld", vld[n], 1);
        check("det_a", det_a, sym[n]);
        if (acc_cnt[n] == 0) begin
          check("flush_first", saw_rst, 1);
          saw_rst = 1'b0;
        end
        if (bq[n].size() == 1 && order.size()) begin
          void'(order.pop_front());
          if (order.size()) begin
            gap_chk = 1'b1;
            gap_start = cyc;
          end
        end
      end
    acc_prev = r[0] | r[1];
    prev_rst = det_rst;
    rdy_s = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++)
      if (rdy_s[n]) begin
        void'(bq[n].pop_front());
        acc_cnt[n]++;
        if (bq[n].size()) begin
          if (force_stall[n] > 0) begin
            stall_left[n] = force_stall[n];
            force_stall[n] = 0;
          end else if ($urandom_range(0, 3) == 0) stall_left[n] = $urandom_range(1, 2);
        end
      end
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic load(input int n, input int len);
    for (int k = 0; k < len; k++) bq[n].push_back(2'($urandom));
  endtask

  // mode 0/1: that requester alone; mode 2: both raise vld in the same cycle
  task automatic plan(input int mode);
    int s;
    acc_cnt = '{0, 0};
    stall_left = '{0, 0};
    order.delete();
    if (mode == 2) begin
      order.push_back(1 - last_w);
      order.push_back(last_w);
    end else order.push_back(mode);
    last_w = order[order.size() - 1];
    foreach (order[i]) begin
      s = 0;
      foreach (bq[order[i]][k]) begin
        s = (s + int'(bq[order[i]][k])) % 4;
        exp_q.push_back(order[i] * 4 + s);
      end
    end
    drive();
  endtask

  task automatic finish_all();
    int k;
    k = 0;
    while (!(bq[0].size() == 0 && bq[1].size() == 0 && exp_q.size() == 0 &&
             order.size() == 0 && busy == 1'b0) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check("done_timeout", 0, 1);
  endtask

  task automatic clear_model();
    bq[0].delete();
    bq[1].delete();
    exp_q.delete();
    order.delete();
    stall_left = '{0, 0};
    force_stall = '{0, 0};
    rdy_s = '{1'b0, 1'b0};
    acc_prev = 1'b0;
    saw_rst = 1'b0;
    prev_rst = 1'b0;
    gap_chk = 1'b0;
    drive();
  endtask

  task automatic chk_zero(input string tag);
    check(tag, {rdy0, rdy1, det_rst, det_en, det_a, res_vld, res_id, res_y}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    last_w = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int k, mode;
    do_reset();
    repeat (2) begin
      load(0, $urandom_range(1, 4));
      load(1, $urandom_range(1, 4));
      plan(2);
      finish_all();
    end
    do_reset();
    bq[0] = '{2'd1, 2'd2, 2'd3};
    plan(0);
    finish_all();
    load(1, 5);
    force_stall[1] = 3;
    plan(1);
    finish_all();
`ifdef SYM_ARB_TIMEOUT_EN
    bq[1] = '{2'd2, 2'd1, 2'd3};
    force_stall[1] = 10;
    plan(1);
    k = 0;
    while (acc_cnt[1] == 0 && k < 20) begin
      step();
      k++;
    end
    for (int s = 1; s <= 4; s++) begin
      if (s > 1) step();
      check("to_rst", det_rst, s == 4);
      check("to_busy", busy, 1);
    end
    step();
    check("to_idle", busy, 0);
    check("to_no_res", res_vld, 0);
    clear_model();
`else
    load(1, 3);
    force_stall[1] = 20;
    plan(1);
    k = 0;
    while (acc_cnt[1] == 0 && k < 20) begin
      step();
      k++;
    end
    for (int s = 1; s <= 20; s++) begin
      if (s > 1) step();
      check("stall_busy", busy, 1);
      check("stall_en", det_en, 0);
    end
    finish_all();
`endif
    load(0, 4);
    plan(0);
    k = 0;
    while (acc_cnt[0] < 2 && k < 20) begin
      step();
      k++;
    end
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    clear_model();
    last_w = 1;
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    load(1, 3);
    plan(1);
    finish_all();
    repeat (40) begin
      mode = $urandom_range(0, 2);
      if (mode != 1) load(0, $urandom_range(1, 4));
      if (mode != 0) load(1, $urandom_range(1, 4));
      plan(mode);
      finish_all();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sym_arbiter.md
SYM_ARBITER -- requirements
Module: sym_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, idle cycles before a stalled burst aborts (used only with SYM_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports reqN_vld, input, 1, for N=0,1: requester N presents a symbol.
REQ-005 SHALL have ports reqN_sym, input, 2, for N=0,1: the symbol.
REQ-006 SHALL have ports reqN_last, input, 1, for N=0,1: final symbol of the burst.
REQ-007 SHALL have ports reqN_rdy, output, 1, for N=0,1: symbol accepted this cycle.
REQ-008 SHALL have port det_rst, output, 1, synchronous clear to the shared Moore detector.
REQ-009 SHALL have port det_en, output, 1, detector advances on det_a this edge.
REQ-010 SHALL have port det_a, output, 2, symbol to the detector.
REQ-011 SHALL have port det_y, input, 2, detector Moore output.
REQ-012 SHALL have ports res_vld (output, 1, result valid), res_id (output, 1, owning requester) and res_y (output, 2, det_y copy).
REQ-013 SHALL have port busy, output, 1, a burst is granted.

Function
REQ-014 SHALL implement FSM IDLE, FLUSH, RUN, DRAIN.
REQ-015 IDLE: any reqN_vld -> FLUSH, grant latched; both valid -> requester not granted last wins (round-robin).
REQ-016 FLUSH: det_rst=1 for exactly one cycle, no rdy -> RUN; detector state never leaks between bursts.
REQ-017 RUN: granted reqN_vld=1 -> reqN_rdy=1, det_en=1, det_a=reqN_sym, same cycle (combinational).
REQ-018 RUN: granted reqN_vld=0 -> stall, det_en=0, rdy=0, no result.
REQ-019 Ungranted requester's rdy SHALL stay 0 for the whole burst.
REQ-020 Accepted symbol with reqN_last=1 -> DRAIN.
REQ-021 Result latency: one cycle after each accepting edge, res_vld=1, res_y=det_y, res_id=grant, registered.
REQ-022 DRAIN: emits last result, grant pointer updated -> IDLE; busy=1 in FLUSH, RUN, DRAIN.
REQ-023 New request during DRAIN SHALL wait for IDLE; a new burst needs one IDLE cycle.

Reset
REQ-024 rst SHALL force IDLE asynchronously, from any state including mid-burst.
REQ-025 During reset, all outputs SHALL be 0: rdy, det_rst, det_en, det_a, res_vld, res_id, res_y and busy.
REQ-026 Reset SHALL set last-grant to 1, so req0 wins the first simultaneous request.
REQ-027 Partial burst results SHALL be discarded on reset.

Configuration
REQ-028 With SYM_ARB_TIMEOUT_EN defined, SHALL abort a RUN stalled TIMEOUT consecutive cycles -> IDLE, one-cycle det_rst pulse, no res_vld, grant pointer advanced.
REQ-029 Without it, a stall SHALL persist indefinitely and the counter SHALL be absent.

Structure
REQ-030 Package sym_arb_pkg SHALL hold the state enum, SYM_W=2 and the result struct {id, y}.
REQ-031 2-way round-robin selection SHALL be sub-module rr_pick2 (req[1:0], last, grant).

Verification
REQ-032 After reset, req0 burst 01,10,11(last) -> det_rst pulse then det_a 01,10,11 on consecutive cycles; three res_vld, res_id=0, res_y=det_y.
REQ-033 req0/req1 valid same cycle twice -> grants 0 then 1; the ungranted rdy stays 0 throughout.
REQ-034 req1 drops vld 3 cycles mid-burst -> det_en=0 and no res_vld for those 3 cycles; stream then resumes in order.
REQ-035 rst mid-RUN -> all outputs 0 immediately; next req1-only burst gets FLUSH then RUN.
REQ-036 SYM_ARB_TIMEOUT_EN, TIMEOUT=4, stall 4 cycles -> IDLE, det_rst pulse, busy=0; without the macro still RUN after 20 cycles.
